// File: rtl/hazard_stall_ctl_pkg.sv
// Shared types and stall-cause codes for the hazard interlock controller.
// History depth and cause encodings live here so the bench and RTL agree on them.
package hazard_stall_ctl_pkg;

    localparam int HIST_DEPTH = 3;

    typedef enum logic [1:0] {
        STALL_NONE    = 2'd0,
        STALL_LOADUSE = 2'd1,
        STALL_CMP     = 2'd2,
        STALL_MULDIV  = 2'd3
    } stallCause_e;

    typedef struct packed {
        logic [4:0] dest;
        logic       isLoad;
    } histEntry_t;

    // r0 is never a producer, so a zero destination can never match.
    function automatic logic srcMatch(histEntry_t h, logic [4:0] src, logic srcValid);
        return srcValid && (h.dest != 5'd0) && (h.dest == src);
    endfunction

endpackage

// File: rtl/hazard_muldiv_timer.sv
// HI/LO busy timer: loads on an accepted mult/div issue and counts down to idle.
// Only instantiated when HAZARD_MULDIV_EN is defined.
module hazard_muldiv_timer #(
    parameter int CYCLES = 32
) (
    input  logic CLK,
    input  logic RESET,
    input  logic Load,
    output logic Busy
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    // The issue cycle itself counts as the first of CYCLES, so the counter
    // only has to cover the remaining CYCLES-1 cycles.
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (Load) begin
            count <= LOAD_VAL;
        end else if (count != '0) begin
            count <= count - CW'(1);
        end
    end

    assign Busy = (count != '0);

endmodule

// File: rtl/hazard_stall_ctl.sv
// ID-stage interlock: stalls IF/ID and bubbles EXE for load-use, ID compare and
// (with HAZARD_MULDIV_EN defined) mult/div HI/LO hazards.
module hazard_stall_ctl
    import hazard_stall_ctl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      Instr,
    input  logic             InstrValid,
    input  logic             RegWrite,
    input  logic             RegDest,
    input  logic             UsesRt,
    input  logic             MemRead,
    input  logic             CmpInID,
    input  logic             MulDivStart,
    input  logic             ReadsHiLo,
    output logic             Stall,
    output logic             Bubble,
    output logic [1:0]       StallCause,
    output logic [CNT_W-1:0] StallCnt
);

    histEntry_t  hist [HIST_DEPTH];
    histEntry_t  issueEntry;
    logic [4:0]  rsAddr;
    logic [4:0]  rtAddr;
    logic [4:0]  rdAddr;
    logic        matchH0;
    logic        matchH1;
    logic        loadUseHaz;
    logic        cmpHaz;
    logic        mulDivHaz;
    logic        stallAny;
    stallCause_e cause;
    logic        unusedBits;

    assign rsAddr = Instr[25:21];
    assign rtAddr = Instr[20:16];
    assign rdAddr = Instr[15:11];

    assign issueEntry.dest   = (RegWrite && InstrValid) ? (RegDest ? rdAddr : rtAddr) : 5'd0;
    assign issueEntry.isLoad = MemRead;

    assign matchH0 = srcMatch(hist[0], rsAddr, 1'b1) || srcMatch(hist[0], rtAddr, UsesRt);
    assign matchH1 = srcMatch(hist[1], rsAddr, 1'b1) || srcMatch(hist[1], rtAddr, UsesRt);

    assign loadUseHaz = InstrValid && hist[0].isLoad && matchH0;
    assign cmpHaz     = InstrValid && CmpInID && (matchH0 || (hist[1].isLoad && matchH1));

`ifdef HAZARD_MULDIV_EN
    logic mulDivBusy;

    hazard_muldiv_timer #(
        .CYCLES (MULDIV_CYCLES)
    ) uMulDivTimer (
        .CLK   (CLK),
        .RESET (RESET),
        .Load  (MulDivStart && !stallAny && InstrValid),
        .Busy  (mulDivBusy)
    );

    assign mulDivHaz  = InstrValid && mulDivBusy && (ReadsHiLo || MulDivStart);
    assign unusedBits = ^{Instr[31:26], Instr[10:0]};
`else
    assign mulDivHaz  = 1'b0;
    assign unusedBits = ^{Instr[31:26], Instr[10:0], MulDivStart, ReadsHiLo};
`endif

    assign stallAny = loadUseHaz || cmpHaz || mulDivHaz;

    // Compare hazards win the reported cause; Stall itself is the OR of all three.
    always_comb begin
        cause = STALL_NONE;
        if (cmpHaz) begin
            cause = STALL_CMP;
        end else if (loadUseHaz) begin
            cause = STALL_LOADUSE;
        end else if (mulDivHaz) begin
            cause = STALL_MULDIV;
        end
    end

    assign Stall      = stallAny;
    assign Bubble     = stallAny;
    assign StallCause = cause;

    // A stalled cycle pushes a bubble into EXE while the ID instruction is held.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= stallAny ? histEntry_t'('0) : issueEntry;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            StallCnt <= '0;
        end else if (stallAny && !(&StallCnt)) begin
            StallCnt <= StallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctl.sv
// Directed bench for hazard_stall_ctl with a per-cycle expectation queue.
// Mult/div expectations follow HAZARD_MULDIV_EN.
module tb_hazard_stall_ctl;

    localparam int CNT_W  = 4;
    localparam int MD_CYC = 4;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [7:0] V   = 8'h80;
    localparam logic [7:0] RW  = 8'h40;
    localparam logic [7:0] RD  = 8'h20;
    localparam logic [7:0] RT  = 8'h10;
    localparam logic [7:0] MR  = 8'h08;
    localparam logic [7:0] CMP = 8'h04;
    localparam logic [7:0] MD  = 8'h02;
    localparam logic [7:0] HL  = 8'h01;

    logic             CLK;
    logic             RESET;
    logic [31:0]      Instr;
    logic             InstrValid, RegWrite, RegDest, UsesRt, MemRead, CmpInID, MulDivStart, ReadsHiLo;
    logic             Stall, Bubble;
    logic [1:0]       StallCause;
    logic [CNT_W-1:0] StallCnt;

    hazard_stall_ctl #(
        .MULDIV_CYCLES (MD_CYC),
        .CNT_W         (CNT_W)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .RegWrite    (RegWrite),
        .RegDest     (RegDest),
        .UsesRt      (UsesRt),
        .MemRead     (MemRead),
        .CmpInID     (CmpInID),
        .MulDivStart (MulDivStart),
        .ReadsHiLo   (ReadsHiLo),
        .Stall       (Stall),
        .Bubble      (Bubble),
        .StallCause  (StallCause),
        .StallCnt    (StallCnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic             stall;
        logic [1:0]       cause;
        logic [CNT_W-1:0] cnt;
        string            tag;
    } exp_t;

    exp_t             expQ[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] modelCnt = '0;

    function automatic logic [31:0] rI(input int rs, input int rt, input int rd);
        logic [31:0] w;
        w = 32'h0;
        w[25:21] = 5'(rs);
        w[20:16] = 5'(rt);
        w[15:11] = 5'(rd);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic [7:0] ctl);
        Instr       = ins;
        InstrValid  = ctl[7];
        RegWrite    = ctl[6];
        RegDest     = ctl[5];
        UsesRt      = ctl[4];
        MemRead     = ctl[3];
        CmpInID     = ctl[2];
        MulDivStart = ctl[1];
        ReadsHiLo   = ctl[0];
    endtask

    task automatic pushExp(input logic eStall, input logic [1:0] eCause, input string tag);
        exp_t e;
        e.stall = eStall;
        e.cause = eCause;
        e.cnt   = modelCnt;
        e.tag   = tag;
        expQ.push_back(e);
        if (eStall && modelCnt != {CNT_W{1'b1}}) modelCnt = modelCnt + 1'b1;
    endtask

    task automatic popCheck();
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = expQ.pop_front();
        chk({e.tag, "_stall"},  32'(Stall),      32'(e.stall));
        chk({e.tag, "_bubble"}, 32'(Bubble),     32'(e.stall));
        chk({e.tag, "_cause"},  32'(StallCause), 32'(e.cause));
        chk({e.tag, "_cnt"},    32'(StallCnt),   32'(e.cnt));
    endtask

    // One ID cycle: drive, record expectation, sample mid-cycle, advance.
    task automatic step(input logic [31:0] ins, input logic [7:0] ctl,
                        input logic eStall, input logic [1:0] eCause, input string tag);
        drive(ins, ctl);
        pushExp(eStall, eCause, tag);
        @(negedge CLK);
        popCheck();
        @(posedge CLK);
        #1;
    endtask

    // Pull reset low mid-cycle and confirm outputs clear without a clock edge.
    task automatic resetPulse(input string tag);
        #2 RESET = 1'b0;
        #1;
        modelCnt = '0;
        chk({tag, "_stall"},  32'(Stall),      32'd0);
        chk({tag, "_bubble"}, 32'(Bubble),     32'd0);
        chk({tag, "_cause"},  32'(StallCause), 32'd0);
        chk({tag, "_cnt"},    32'(StallCnt),   32'd0);
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        drive(32'h0, 8'h00);
        #3;
        chk("rst_stall", 32'(Stall),      32'd0);
        chk("rst_cause", 32'(StallCause), 32'd0);
        chk("rst_cnt",   32'(StallCnt),   32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // load -> ALU use
        step(rI(1, 2, 0), V|RW|MR,     1'b0, 2'd0, "t1_lw");
        step(rI(2, 4, 3), V|RW|RD|RT,  1'b1, 2'd1, "t1_use");
        step(rI(2, 4, 3), V|RW|RD|RT,  1'b0, 2'd0, "t1_issue");

        // ALU -> branch, then load -> branch
        step(rI(1, 1, 5), V|RW|RD|RT,  1'b0, 2'd0, "t2_add");
        step(rI(5, 6, 0), V|RT|CMP,    1'b1, 2'd2, "t2_beq");
        step(rI(5, 6, 0), V|RT|CMP,    1'b0, 2'd0, "t2_beq_go");
        step(rI(1, 5, 0), V|RW|MR,     1'b0, 2'd0, "t2_lw");
        step(rI(5, 6, 0), V|RT|CMP,    1'b1, 2'd2, "t2_lbeq1");
        step(rI(5, 6, 0), V|RT|CMP,    1'b1, 2'd2, "t2_lbeq2");
        step(rI(5, 6, 0), V|RT|CMP,    1'b0, 2'd0, "t2_lbeq_go");

        // r0 and invalid slots never hazard
        step(rI(1, 0, 0), V|RW|MR,     1'b0, 2'd0, "t3_lw0");
        step(rI(0, 0, 3), V|RW|RD|RT,  1'b0, 2'd0, "t3_use0");
        step(rI(1, 7, 0), RW|MR,       1'b0, 2'd0, "t3_lw7_inv");
        step(rI(7, 1, 3), V|RW|RD|RT,  1'b0, 2'd0, "t3_use7");
        step(rI(1, 9, 0), V|RW|MR,     1'b0, 2'd0, "t3_lw9");
        step(rI(9, 1, 3), RW|RD|RT,    1'b0, 2'd0, "t3_use9_inv");

        // load feeding a branch: both hazards, compare reported
        step(rI(1, 8, 0), V|RW|MR,     1'b0, 2'd0, "t5_lw8");
        step(rI(8, 0, 0), V|CMP,       1'b1, 2'd2, "t5_beq1");
        step(rI(8, 0, 0), V|CMP,       1'b1, 2'd2, "t5_beq2");
        step(rI(8, 0, 0), V|CMP,       1'b0, 2'd0, "t5_go");

        // mult then mflo
        step(rI(1, 2, 0), V|RT|MD,     1'b0, 2'd0, "t4_mult");
        for (int i = 0; i < MD_CYC - 1; i++)
            step(rI(0, 0, 3), V|RW|RD|HL, MD_EN, MD_EN ? 2'd3 : 2'd0, "t4_mflo_wait");
        step(rI(0, 0, 3), V|RW|RD|HL,  1'b0, 2'd0, "t4_mflo_go");

        // reset during a load-use stall
        step(rI(1, 2, 0), V|RW|MR,     1'b0, 2'd0, "t6_lw");
        drive(rI(2, 4, 3), V|RW|RD|RT);
        pushExp(1'b1, 2'd1, "t6_stall");
        @(negedge CLK);
        popCheck();
        resetPulse("t6_rst_lu");
        step(rI(2, 4, 3), V|RW|RD|RT,  1'b0, 2'd0, "t6_after_lu");

        // reset during mult/div busy
        step(rI(1, 2, 0), V|RT|MD,     1'b0, 2'd0, "t6_mult");
        drive(rI(0, 0, 3), V|RW|RD|HL);
        pushExp(MD_EN, MD_EN ? 2'd3 : 2'd0, "t6_mflo");
        @(negedge CLK);
        popCheck();
        resetPulse("t6_rst_md");
        step(rI(0, 0, 3), V|RW|RD|HL,  1'b0, 2'd0, "t6_after_md");

        // saturation of the stall counter
        for (int i = 0; i < 20; i++) begin
            step(rI(1, 2, 0), V|RW|MR,    1'b0, 2'd0, "sat_lw");
            step(rI(2, 4, 3), V|RW|RD|RT, 1'b1, 2'd1, "sat_use");
            step(rI(2, 4, 3), V|RW|RD|RT, 1'b0, 2'd0, "sat_go");
        end
        @(negedge CLK);
        chk("sat_final", 32'(StallCnt), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
